smz_crypt_engine: RTL
=====================

Name: smz_crypt_engine

Overview:
- Multi-region, pipelined successor to the single-region SMZ XOR layer.
- Sits between the picorv32 native memory interface and system memory, and owns the valid/ready handshake on both sides.
- Matches each request against NUM_REGIONS configurable secure windows and derives a per-access keystream from a per-region key over ROUNDS iterative cycles.
- Encrypts writes and decrypts reads in secure windows; all other accesses pass through unchanged.

Parameters:
- NUM_REGIONS, 4, number of secure windows (1..8).
- ROUNDS, 4, keystream mixing cycles per secure access (1..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_mem_valid  in  1  CPU request valid, held until cpu_mem_ready
- cpu_mem_ready  out  1  one-cycle response strobe
- cpu_mem_addr  in  32  CPU byte address
- cpu_mem_wdata  in  32  CPU write data
- cpu_mem_wstrb  in  4  byte strobes; 0 means read
- cpu_mem_rdata  out  32  read data to CPU, decrypted if secure
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory completion
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data, encrypted if secure
- mem_wstrb  out  4  memory byte strobes
- mem_rdata  in  32  raw memory read data
- region_base  in  32*NUM_REGIONS  window i base at [32i+31:32i]
- region_size  in  32*NUM_REGIONS  window i size in bytes
- region_en  in  NUM_REGIONS  window enables
- region_key  in  32*NUM_REGIONS  window keys
- hit_region  out  4  index of matched window for the current transaction; 4'hF if bypass
- secure_count  out  32  count of completed secure transactions, saturating

Behaviour:
- States: IDLE, KEYGEN, MEM, RESP. Registered outputs.
- Reset values: state IDLE, mem_valid 0, cpu_mem_ready 0, all data/address outputs 0, hit_region 4'hF, secure_count 0.
- Reset mid-transaction: return to IDLE next edge and drop mem_valid. The memory transaction is abandoned and no cpu_mem_ready is issued.
- Region match:
  - Window i hits when region_en[i], addr >= base, and (addr - base) < size. Use 32-bit unsigned compare on the difference, so base+size overflow is harmless.
  - size 0 never hits.
  - On multiple hits, the lowest index wins.
- IDLE, when cpu_mem_valid is 1:
  - Latch addr, wdata, wstrb, the match result and the matched key.
  - Config changes after this point do not affect the transaction.
  - Hit: ks <= addr ^ key, cnt <= ROUNDS, go to KEYGEN.
  - Miss: ks <= 0, go to MEM.
- KEYGEN:
  - Each cycle: ks <= {ks[30:0], ks[31]} ^ key (rotate-left-by-1, then XOR key); cnt decrements.
  - Lasts exactly ROUNDS cycles, then go to MEM.
- MEM:
  - mem_valid = 1, mem_addr = latched addr, mem_wstrb = latched wstrb, mem_wdata = latched wdata ^ ks.
  - On mem_ready: capture mem_rdata ^ ks, deassert mem_valid, go to RESP.
  - Holds indefinitely while mem_ready is 0.
- RESP:
  - cpu_mem_ready = 1 for exactly one cycle; cpu_mem_rdata holds the captured value.
  - Secure transaction: secure_count += 1, saturating at 32'hFFFFFFFF.
  - Go to IDLE. cpu_mem_valid seen in IDLE on the next cycle is treated as a new request.
- Latency:
  - Accept edge to mem_valid: 1 cycle bypass, 1+ROUNDS cycles secure.
  - mem_ready to cpu_mem_ready: 1 cycle.
- Partial writes: the byte-wise XOR covers all lanes. Strobes pass through unchanged, so unstrobed lanes are don't-care.
- Data stability: cpu_mem_rdata and hit_region hold until the next accept.
- cpu_mem_valid dropping mid-transaction is a protocol violation; the transaction still completes.
- mem_ready outside MEM is ignored.

Test Plan:
- Bypass read, no region enabled, addr 0x0000_2000, mem_rdata 0xCAFEBABE with mem_ready 2 cycles after mem_valid -> mem_wdata/rdata unmodified, cpu_mem_rdata 0xCAFEBABE, hit_region 4'hF, secure_count 0.
- ROUNDS=1, region0 base 0x100, size 0x100, key 0, write 0x12345678 to 0x100 -> mem_valid 2 cycles after accept, mem_wdata 0x12345478 (ks 0x200), hit_region 0, secure_count 1.
- Same config, read 0x100 with mem_rdata 0x12345478 -> cpu_mem_rdata 0x12345678 (round trip).
- Overlap: region1 and region2 both cover 0x4000 -> hit_region 1 and region1's key used; addr base+size-1 hits, addr base+size misses; base 0xFFFF_FF00, size 0x200 hits at 0xFFFF_FFFC.
- Reset pulsed during KEYGEN and again during MEM with mem_ready held low -> mem_valid 0 and state IDLE on the next edge, no cpu_mem_ready, secure_count unchanged; the next request completes normally.
- region_key changed during KEYGEN -> keystream uses the latched key. Force secure_count to 0xFFFFFFFF -> it stays saturated after a further secure access.

Source files
------------

// File: rtl/smz_crypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : smz_crypt_engine
// Description : Multi-region XOR crypt layer between the picorv32 native
//               memory bus and system memory, with iterative keystream.
// Revision    : 1.0 - initial release
// ============================================================================
module smz_crypt_engine #(
    parameter int NUM_REGIONS = 4,
    parameter int ROUNDS      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_mem_valid,
    output logic                      cpu_mem_ready,
    input  logic [31:0]               cpu_mem_addr,
    input  logic [31:0]               cpu_mem_wdata,
    input  logic [3:0]                cpu_mem_wstrb,
    output logic [31:0]               cpu_mem_rdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic [31:0]               mem_rdata,
    input  logic [32*NUM_REGIONS-1:0] region_base,
    input  logic [32*NUM_REGIONS-1:0] region_size,
    input  logic [NUM_REGIONS-1:0]    region_en,
    input  logic [32*NUM_REGIONS-1:0] region_key,
    output logic [3:0]                hit_region,
    output logic [31:0]               secure_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_KEYGEN = 2'd1;
    localparam logic [1:0] c_MEM    = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;
    localparam int         c_CNT_W  = 5;

    logic [1:0]          r_state, w_state_nxt;
    logic [31:0]         r_addr, r_wdata, r_key, r_ks;
    logic [3:0]          r_wstrb;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_secure;

    logic                r_mem_valid, r_cpu_ready;
    logic [31:0]         r_cpu_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]          r_mem_wstrb, r_hit_region;
    logic [31:0]         r_secure_count;

    logic [NUM_REGIONS-1:0] w_hit;
    logic                w_any_hit;
    logic [3:0]          w_hit_idx;
    logic [31:0]         w_key;
    logic [31:0]         w_ks_round;
    logic                w_accept, w_kg_done, w_mem_done, w_resp;

    // Offset compare makes windows that wrap past 2^32 behave correctly.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            logic [31:0] w_base, w_size, w_off;
            assign w_base    = region_base[32*gi +: 32];
            assign w_size    = region_size[32*gi +: 32];
            assign w_off     = cpu_mem_addr - w_base;
            assign w_hit[gi] = region_en[gi] && (cpu_mem_addr >= w_base) && (w_off < w_size);
        end
    endgenerate

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_any_hit = 1'b0;
        w_hit_idx = 4'hF;
        w_key     = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit = 1'b1;
                w_hit_idx = 4'(i);
                w_key     = region_key[32*i +: 32];
            end
        end
    end

    assign w_ks_round = {r_ks[30:0], r_ks[31]} ^ r_key;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (cpu_mem_valid) w_state_nxt = w_any_hit ? c_KEYGEN : c_MEM;
            c_KEYGEN: if (r_cnt <= c_CNT_W'(1)) w_state_nxt = c_MEM;
            c_MEM:    if (mem_ready) w_state_nxt = c_RESP;
            c_RESP:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == c_IDLE) && cpu_mem_valid;
        w_kg_done  = (r_state == c_KEYGEN) && (r_cnt <= c_CNT_W'(1));
        w_mem_done = (r_state == c_MEM) && mem_ready;
        w_resp     = (r_state == c_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_key          <= '0;
            r_ks           <= '0;
            r_cnt          <= '0;
            r_secure       <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_cpu_ready    <= 1'b0;
            r_cpu_rdata    <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_wstrb    <= '0;
            r_hit_region   <= 4'hF;
            r_secure_count <= '0;
        end else begin
            if (w_accept) begin
                r_addr       <= cpu_mem_addr;
                r_wdata      <= cpu_mem_wdata;
                r_wstrb      <= cpu_mem_wstrb;
                r_key        <= w_key;
                r_secure     <= w_any_hit;
                r_hit_region <= w_hit_idx;
                if (w_any_hit) begin
                    r_ks  <= cpu_mem_addr ^ w_key;
                    r_cnt <= c_CNT_W'(ROUNDS);
                end else begin
                    r_ks        <= '0;
                    r_mem_valid <= 1'b1;
                    r_mem_addr  <= cpu_mem_addr;
                    r_mem_wdata <= cpu_mem_wdata;
                    r_mem_wstrb <= cpu_mem_wstrb;
                end
            end
            if (r_state == c_KEYGEN) begin
                r_ks  <= w_ks_round;
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (w_kg_done) begin
                    r_mem_valid <= 1'b1;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= r_wdata ^ w_ks_round;
                    r_mem_wstrb <= r_wstrb;
                end
            end
            if (w_mem_done) begin
                r_cpu_rdata <= mem_rdata ^ r_ks;
                r_mem_valid <= 1'b0;
                r_cpu_ready <= 1'b1;
            end
            if (w_resp) begin
                r_cpu_ready <= 1'b0;
                if (r_secure && (r_secure_count != 32'hFFFF_FFFF))
                    r_secure_count <= r_secure_count + 32'd1;
            end
        end
    end

    assign cpu_mem_ready = r_cpu_ready;
    assign cpu_mem_rdata = r_cpu_rdata;
    assign mem_valid     = r_mem_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wstrb     = r_mem_wstrb;
    assign hit_region    = r_hit_region;
    assign secure_count  = r_secure_count;

endmodule
`default_nettype wire
